qa_driver_csr_wr: RTL and testbench

// - Write-side CSR handler for the QA driver; counterpart of the MMIO CSR read path.
// - Consumes host MMIO writes from the FIU c0Rx stream and updates local control registers.
// - 64-bit values assemble atomically from 32-bit halves.
// - SREG writes are queued toward LEAP through a small buffer with a valid/ready handshake.

---
 rtl/qa_driver_csr_wr.sv | 180 ++++++++++++++++++
 tb/tb_qa_driver_csr_wr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qa_driver_csr_wr.sv
// Write-side CSR handler: host MMIO writes -> DSM/ENABLE CSRs and a LEAP SREG write queue.
// Optional scratch register at DWORD 16/17 when QA_DRIVER_CSR_WR_SCRATCH_EN is defined.
module qa_driver_csr_wr #(
    parameter int unsigned SREG_FIFO_DEPTH = 2,
    parameter int unsigned SREG_ADDR_BITS  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mmio_wr_valid,
    input  logic [15:0]               mmio_wr_addr,
    input  logic                      mmio_wr_len8,
    input  logic [63:0]               mmio_wr_data,
    output logic [63:0]               csr_dsm_base,
    output logic                      csr_dsm_update,
    output logic                      csr_enable,
    output logic                      sreg_wr_valid,
    input  logic                      sreg_wr_ready,
    output logic [SREG_ADDR_BITS-1:0] sreg_wr_addr,
    output logic [63:0]               sreg_wr_data,
    output logic                      sreg_wr_overflow
`ifdef QA_DRIVER_CSR_WR_SCRATCH_EN
    ,
    output logic [63:0]               csr_scratch,
    output logic                      csr_scratch_update
`endif
);

    localparam int unsigned PTR_W   = $clog2(SREG_FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = SREG_ADDR_BITS + 64;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SREG_FIFO_DEPTH);

    localparam logic [15:0] ADDR_DSM_L   = 16'd8;
    localparam logic [15:0] ADDR_DSM_H   = 16'd9;
    localparam logic [15:0] ADDR_ENABLE  = 16'd10;
    localparam logic [15:0] ADDR_WADDR   = 16'd12;
    localparam logic [15:0] ADDR_SDATA_L = 16'd14;
    localparam logic [15:0] ADDR_SDATA_H = 16'd15;

    typedef enum logic {StIdle, StLoHeld} asm_state_e;

    logic wr4, wr8, wr_any;

    // 8B writes to odd addresses are dropped entirely.
    always_comb begin
        wr4    = mmio_wr_valid & ~mmio_wr_len8;
        wr8    = mmio_wr_valid & mmio_wr_len8 & ~mmio_wr_addr[0];
        wr_any = wr4 | wr8;
    end

    asm_state_e  dsm_state_q;
    logic [31:0] dsm_lo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dsm_state_q    <= StIdle;
            dsm_lo_q       <= '0;
            csr_dsm_base   <= '0;
            csr_dsm_update <= 1'b0;
        end else begin
            csr_dsm_update <= 1'b0;
            if (wr8 && mmio_wr_addr == ADDR_DSM_L) begin
                csr_dsm_base   <= mmio_wr_data;
                csr_dsm_update <= 1'b1;
                dsm_state_q    <= StIdle;
            end else if (wr4 && mmio_wr_addr == ADDR_DSM_L) begin
                dsm_lo_q    <= mmio_wr_data[31:0];
                dsm_state_q <= StLoHeld;
            end else if (wr4 && mmio_wr_addr == ADDR_DSM_H && dsm_state_q == StLoHeld) begin
                csr_dsm_base   <= {mmio_wr_data[31:0], dsm_lo_q};
                csr_dsm_update <= 1'b1;
                dsm_state_q    <= StIdle;
            end
        end
    end

`ifdef QA_DRIVER_CSR_WR_SCRATCH_EN
    asm_state_e  scr_state_q;
    logic [31:0] scr_lo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scr_state_q        <= StIdle;
            scr_lo_q           <= '0;
            csr_scratch        <= '0;
            csr_scratch_update <= 1'b0;
        end else begin
            csr_scratch_update <= 1'b0;
            if (wr8 && mmio_wr_addr == 16'd16) begin
                csr_scratch        <= mmio_wr_data;
                csr_scratch_update <= 1'b1;
                scr_state_q        <= StIdle;
            end else if (wr4 && mmio_wr_addr == 16'd16) begin
                scr_lo_q    <= mmio_wr_data[31:0];
                scr_state_q <= StLoHeld;
            end else if (wr4 && mmio_wr_addr == 16'd17 && scr_state_q == StLoHeld) begin
                csr_scratch        <= {mmio_wr_data[31:0], scr_lo_q};
                csr_scratch_update <= 1'b1;
                scr_state_q        <= StIdle;
            end
        end
    end
`endif

    logic [SREG_ADDR_BITS-1:0] sreg_waddr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_enable   <= 1'b0;
            sreg_waddr_q <= '0;
        end else begin
            if (wr_any && mmio_wr_addr == ADDR_ENABLE) csr_enable <= mmio_wr_data[0];
            if (wr_any && mmio_wr_addr == ADDR_WADDR) begin
                sreg_waddr_q <= mmio_wr_data[SREG_ADDR_BITS-1:0];
            end
        end
    end

    asm_state_e  sreg_state_q;
    logic [31:0] sreg_lo_q;
    logic        sreg_commit;
    logic [63:0] sreg_commit_data;

    always_comb begin
        sreg_commit = (wr8 && mmio_wr_addr == ADDR_SDATA_L) ||
                      (wr4 && mmio_wr_addr == ADDR_SDATA_H && sreg_state_q == StLoHeld);
        sreg_commit_data = mmio_wr_len8 ? mmio_wr_data : {mmio_wr_data[31:0], sreg_lo_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg_state_q <= StIdle;
            sreg_lo_q    <= '0;
        end else if (sreg_commit) begin
            sreg_state_q <= StIdle;
        end else if (wr4 && mmio_wr_addr == ADDR_SDATA_L) begin
            sreg_lo_q    <= mmio_wr_data[31:0];
            sreg_state_q <= StLoHeld;
        end
    end

    logic [ENTRY_W-1:0] mem_q [SREG_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               pop, push_ok;

    // A pop frees the head slot in the same cycle, so a full queue still accepts a push.
    always_comb begin
        pop     = (count_q != '0) && sreg_wr_ready;
        push_ok = sreg_commit && ((count_q != FULL_CNT) || pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SREG_FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            sreg_wr_overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {sreg_waddr_q, sreg_commit_data};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (sreg_commit && !push_ok) sreg_wr_overflow <= 1'b1;
        end
    end

    always_comb begin
        sreg_wr_valid                = (count_q != '0);
        {sreg_wr_addr, sreg_wr_data} = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_qa_driver_csr_wr.sv
// Directed self-checking bench for qa_driver_csr_wr (default build, DEPTH=2).
module tb_qa_driver_csr_wr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic        mmio_wr_len8;
    logic [63:0] mmio_wr_data;
    logic [63:0] csr_dsm_base;
    logic        csr_dsm_update;
    logic        csr_enable;
    logic        sreg_wr_valid;
    logic        sreg_wr_ready;
    logic [15:0] sreg_wr_addr;
    logic [63:0] sreg_wr_data;
    logic        sreg_wr_overflow;

    int checks   = 0;
    int failures = 0;

    qa_driver_csr_wr #(
        .SREG_FIFO_DEPTH(2),
        .SREG_ADDR_BITS (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mmio_wr_valid   (mmio_wr_valid),
        .mmio_wr_addr    (mmio_wr_addr),
        .mmio_wr_len8    (mmio_wr_len8),
        .mmio_wr_data    (mmio_wr_data),
        .csr_dsm_base    (csr_dsm_base),
        .csr_dsm_update  (csr_dsm_update),
        .csr_enable      (csr_enable),
        .sreg_wr_valid   (sreg_wr_valid),
        .sreg_wr_ready   (sreg_wr_ready),
        .sreg_wr_addr    (sreg_wr_addr),
        .sreg_wr_data    (sreg_wr_data),
        .sreg_wr_overflow(sreg_wr_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one write for one cycle and returns at the next negedge,
    // by which time the write has taken effect.
    task automatic wr(input logic len8, input logic [15:0] addr, input logic [63:0] data);
        mmio_wr_valid = 1'b1;
        mmio_wr_len8  = len8;
        mmio_wr_addr  = addr;
        mmio_wr_data  = data;
        @(negedge clk);
        mmio_wr_valid = 1'b0;
        mmio_wr_len8  = 1'b0;
        mmio_wr_addr  = '0;
        mmio_wr_data  = '0;
    endtask

    initial begin
        reset_n       = 1'b0;
        mmio_wr_valid = 1'b0;
        mmio_wr_addr  = '0;
        mmio_wr_len8  = 1'b0;
        mmio_wr_data  = '0;
        sreg_wr_ready = 1'b0;
        #3;
        chk("rst_base", csr_dsm_base, 64'h0);
        chk("rst_update", {63'h0, csr_dsm_update}, 64'h0);
        chk("rst_enable", {63'h0, csr_enable}, 64'h0);
        chk("rst_valid", {63'h0, sreg_wr_valid}, 64'h0);
        chk("rst_ovf", {63'h0, sreg_wr_overflow}, 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // DSM 8B direct commit
        wr(1'b1, 16'd8, 64'h0000_1234_5678_9000);
        chk("dsm8_base", csr_dsm_base, 64'h0000_1234_5678_9000);
        chk("dsm8_pulse", {63'h0, csr_dsm_update}, 64'h1);
        @(negedge clk);
        chk("dsm8_pulse_end", {63'h0, csr_dsm_update}, 64'h0);

        // DSM lo/hi assembly
        wr(1'b0, 16'd8, 64'h9000);
        chk("dsm_lo_nocommit", csr_dsm_base, 64'h0000_1234_5678_9000);
        chk("dsm_lo_nopulse", {63'h0, csr_dsm_update}, 64'h0);
        wr(1'b0, 16'd9, 64'h1);
        chk("dsm_hi_base", csr_dsm_base, 64'h0000_0001_0000_9000);
        chk("dsm_hi_pulse", {63'h0, csr_dsm_update}, 64'h1);

        // Hi from IDLE is ignored
        wr(1'b0, 16'd9, 64'h5555);
        chk("dsm_hi_idle_base", csr_dsm_base, 64'h0000_0001_0000_9000);
        chk("dsm_hi_idle_pulse", {63'h0, csr_dsm_update}, 64'h0);

        // Repeated lo overwrites the shadow
        wr(1'b0, 16'd8, 64'h1111);
        wr(1'b0, 16'd8, 64'h2222);
        wr(1'b0, 16'd9, 64'h3);
        chk("dsm_lo_overwrite", csr_dsm_base, 64'h0000_0003_0000_2222);

        // 8B write forces IDLE; following hi does not commit
        wr(1'b0, 16'd8, 64'h4444);
        wr(1'b1, 16'd8, 64'h0000_00AA_0000_00BB);
        chk("dsm8_force_base", csr_dsm_base, 64'h0000_00AA_0000_00BB);
        wr(1'b0, 16'd9, 64'h9);
        chk("dsm8_force_idle", csr_dsm_base, 64'h0000_00AA_0000_00BB);
        chk("dsm8_force_nopulse", {63'h0, csr_dsm_update}, 64'h0);

        // 8B to odd address ignored
        wr(1'b1, 16'd9, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("odd8_base", csr_dsm_base, 64'h0000_00AA_0000_00BB);
        chk("odd8_pulse", {63'h0, csr_dsm_update}, 64'h0);

        // ENABLE
        wr(1'b0, 16'd10, 64'h1);
        chk("enable_set", {63'h0, csr_enable}, 64'h1);
        wr(1'b1, 16'd10, 64'h2);
        chk("enable_clr8", {63'h0, csr_enable}, 64'h0);
        wr(1'b0, 16'd10, 64'hFFFF_FFFF);
        chk("enable_set2", {63'h0, csr_enable}, 64'h1);
        wr(1'b0, 16'd11, 64'h0);
        wr(1'b0, 16'd16, 64'h0);
        chk("unmapped_enable", {63'h0, csr_enable}, 64'h1);
        chk("unmapped_base", csr_dsm_base, 64'h0000_00AA_0000_00BB);

        // SREG single entry, accepted immediately
        wr(1'b0, 16'd12, 64'h0042);
        sreg_wr_ready = 1'b1;
        chk("sreg_pre_valid", {63'h0, sreg_wr_valid}, 64'h0);
        wr(1'b1, 16'd14, 64'hDEAD);
        chk("sreg1_valid", {63'h0, sreg_wr_valid}, 64'h1);
        chk("sreg1_addr", {48'h0, sreg_wr_addr}, 64'h0042);
        chk("sreg1_data", sreg_wr_data, 64'hDEAD);
        @(negedge clk);
        chk("sreg1_drained", {63'h0, sreg_wr_valid}, 64'h0);
        sreg_wr_ready = 1'b0;

        // Full queue with simultaneous push and pop
        wr(1'b0, 16'd12, 64'h0010);
        wr(1'b1, 16'd14, 64'h11);
        wr(1'b1, 16'd14, 64'h22);
        chk("full_head_data", sreg_wr_data, 64'h11);
        wr(1'b0, 16'd12, 64'h0030);
        sreg_wr_ready = 1'b1;
        wr(1'b1, 16'd14, 64'h33);
        sreg_wr_ready = 1'b0;
        chk("pp_ovf", {63'h0, sreg_wr_overflow}, 64'h0);
        chk("pp_head_addr", {48'h0, sreg_wr_addr}, 64'h0010);
        chk("pp_head_data", sreg_wr_data, 64'h22);
        sreg_wr_ready = 1'b1;
        @(negedge clk);
        chk("pp_last_valid", {63'h0, sreg_wr_valid}, 64'h1);
        chk("pp_last_addr", {48'h0, sreg_wr_addr}, 64'h0030);
        chk("pp_last_data", sreg_wr_data, 64'h33);
        @(negedge clk);
        chk("pp_empty", {63'h0, sreg_wr_valid}, 64'h0);
        sreg_wr_ready = 1'b0;

        // Overflow: three commits into DEPTH=2 with ready low
        wr(1'b0, 16'd12, 64'h0100);
        wr(1'b1, 16'd14, 64'hA1);
        wr(1'b0, 16'd12, 64'h0200);
        wr(1'b0, 16'd14, 64'hB2);
        wr(1'b0, 16'd15, 64'h0B);
        wr(1'b0, 16'd12, 64'h0300);
        wr(1'b1, 16'd14, 64'hC3);
        chk("ovf_set", {63'h0, sreg_wr_overflow}, 64'h1);
        chk("ovf_head_addr", {48'h0, sreg_wr_addr}, 64'h0100);
        @(negedge clk);
        chk("ovf_hold_data", sreg_wr_data, 64'hA1);
        sreg_wr_ready = 1'b1;
        @(negedge clk);
        chk("ovf_second_addr", {48'h0, sreg_wr_addr}, 64'h0200);
        chk("ovf_second_data", sreg_wr_data, 64'h0000_000B_0000_00B2);
        @(negedge clk);
        chk("ovf_drained", {63'h0, sreg_wr_valid}, 64'h0);
        chk("ovf_sticky", {63'h0, sreg_wr_overflow}, 64'h1);
        sreg_wr_ready = 1'b0;

        // Async reset mid-operation
        wr(1'b0, 16'd12, 64'h0005);
        wr(1'b1, 16'd14, 64'h77);
        wr(1'b0, 16'd8, 64'hABCD);
        chk("prerst_valid", {63'h0, sreg_wr_valid}, 64'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", {63'h0, sreg_wr_valid}, 64'h0);
        chk("async_ovf", {63'h0, sreg_wr_overflow}, 64'h0);
        chk("async_base", csr_dsm_base, 64'h0);
        chk("async_enable", {63'h0, csr_enable}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wr(1'b0, 16'd9, 64'h1);
        chk("postrst_base", csr_dsm_base, 64'h0);
        chk("postrst_pulse", {63'h0, csr_dsm_update}, 64'h0);
        chk("postrst_valid", {63'h0, sreg_wr_valid}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
